spi_slave_param: RTL and testbench



---
 rtl/spi_slave_param.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: DW+2-bit command frames in, DW-bit read data out on MISO.
// Optional macro SPI_SLAVE_PARITY_EN appends an odd-parity bit to every MISO word.
module spi_slave_param #(
  parameter int DW         = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int TX_TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          SS_n,
  input  logic          MOSI,
  output logic          MISO,
  output logic          rx_valid,
  output logic [DW+1:0] rx_data,
  input  logic          tx_valid,
  input  logic [DW-1:0] tx_data,
  output logic          busy,
  output logic          frame_err
);

  localparam int FW = DW + 2;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int NTX = DW + 1;
`else
  localparam int NTX = DW;
`endif
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(NTX + 1);
  localparam int OW = $clog2(TX_TIMEOUT + 1);
  localparam int TD = 1 << TW;

  localparam logic [CW-1:0] BITS_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] BITS_FULL = CW'(FW);
  localparam logic [TW-1:0] TX_LAST   = TW'(NTX - 1);
  localparam logic [TW-1:0] TX_FULL   = TW'(NTX);
  localparam logic [OW-1:0] TO_LAST   = OW'(TX_TIMEOUT - 1);
  localparam logic [OW-1:0] TO_FULL   = OW'(TX_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_TX
  } state_t;

  state_t          cs_reg, cs_next;
  logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0]   tx_cnt_reg, tx_cnt_next;
  logic [OW-1:0]   to_cnt_reg, to_cnt_next;
  logic [FW-1:0]   rx_shift_reg, rx_shift_next;
  logic [FW-1:0]   rx_data_reg, rx_data_next;
  logic            rx_valid_reg, rx_valid_next;
  logic [NTX-1:0]  tx_word_reg, tx_word_next;
  logic            addr_pending_reg, addr_pending_next;
  logic            miso_reg, miso_next;
  logic            frame_err_reg, frame_err_next;

  logic [FW-1:0]   rx_frame;
  logic [NTX-1:0]  tx_load;
  logic [TD-1:0]   tx_order;

  // Each rx bit position owns the bit-count slot at which it is sampled;
  // command bits always come first, payload order follows LSB_FIRST.
  for (genvar gi = 0; gi < FW; gi++) begin : g_rx_slot
    localparam int SLOT = (gi >= DW || !LSB_FIRST) ? (FW - 1 - gi) : (gi + 2);
    assign rx_frame[gi] = (bit_cnt_reg == CW'(SLOT)) ? MOSI : rx_shift_reg[gi];
  end

`ifdef SPI_SLAVE_PARITY_EN
  assign tx_load = {~^tx_data, tx_data};
`else
  assign tx_load = tx_data;
`endif

  // tx_order[i] is the i-th bit to leave on MISO; padded so tx_cnt indexes it directly.
  for (genvar gi = 0; gi < TD; gi++) begin : g_tx_order
    if (gi < DW) begin : g_data
      assign tx_order[gi] = LSB_FIRST ? tx_word_reg[gi] : tx_word_reg[DW-1-gi];
    end else if (gi < NTX) begin : g_par
      assign tx_order[gi] = tx_word_reg[gi];
    end else begin : g_pad
      assign tx_order[gi] = 1'b0;
    end
  end

  always_comb begin
    cs_next           = cs_reg;
    bit_cnt_next      = bit_cnt_reg;
    tx_cnt_next       = tx_cnt_reg;
    to_cnt_next       = to_cnt_reg;
    rx_shift_next     = rx_shift_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    tx_word_next      = tx_word_reg;
    addr_pending_next = addr_pending_reg;
    miso_next         = 1'b0;
    frame_err_next    = 1'b0;

    if (SS_n) begin
      // Deselect wins over everything; only a partially received or sent frame is an error.
      cs_next      = IDLE;
      bit_cnt_next = '0;
      tx_cnt_next  = '0;
      to_cnt_next  = '0;
      if (cs_reg != IDLE &&
          ((bit_cnt_reg != '0 && bit_cnt_reg != BITS_FULL) ||
           (cs_reg == READ_TX && tx_cnt_reg != TX_FULL)))
        frame_err_next = 1'b1;
    end else begin
      case (cs_reg)
        IDLE: cs_next = CHK_CMD;
        CHK_CMD: begin
          rx_shift_next = rx_frame;
          bit_cnt_next  = CW'(1);
          if (!MOSI)                 cs_next = WRITE;
          else if (!addr_pending_reg) cs_next = READ_ADD;
          else                       cs_next = READ_DATA;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_reg != BITS_FULL) begin
            rx_shift_next = rx_frame;
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BITS_LAST) begin
              rx_data_next  = rx_frame;
              rx_valid_next = 1'b1;
              if (cs_reg == READ_ADD) addr_pending_next = 1'b1;
              if (cs_reg == READ_DATA) begin
                cs_next     = READ_WAIT;
                to_cnt_next = '0;
              end
            end
          end
        end
        READ_WAIT: begin
          // A saturated timeout counter parks the FSM here until deselect.
          if (to_cnt_reg != TO_FULL) begin
            if (tx_valid) begin
              tx_word_next = tx_load;
              tx_cnt_next  = '0;
              cs_next      = READ_TX;
            end else begin
              to_cnt_next = to_cnt_reg + 1'b1;
              if (to_cnt_reg == TO_LAST) frame_err_next = 1'b1;
            end
          end
        end
        READ_TX: begin
          if (tx_cnt_reg != TX_FULL) begin
            miso_next   = tx_order[tx_cnt_reg];
            tx_cnt_next = tx_cnt_reg + 1'b1;
            if (tx_cnt_reg == TX_LAST) addr_pending_next = 1'b0;
          end
        end
        default: cs_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      cs_reg           <= IDLE;
      bit_cnt_reg      <= '0;
      tx_cnt_reg       <= '0;
      to_cnt_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      tx_word_reg      <= '0;
      addr_pending_reg <= 1'b0;
      miso_reg         <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      cs_reg           <= cs_next;
      bit_cnt_reg      <= bit_cnt_next;
      tx_cnt_reg       <= tx_cnt_next;
      to_cnt_reg       <= to_cnt_next;
      rx_shift_reg     <= rx_shift_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      tx_word_reg      <= tx_word_next;
      addr_pending_reg <= addr_pending_next;
      miso_reg         <= miso_next;
      frame_err_reg    <= frame_err_next;
    end
  end

  assign MISO      = miso_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_data   = rx_data_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (cs_reg != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: one MSB-first and one LSB-first instance
// share every input so both orders are checked against the same frames.
module tb_spi_slave_param;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       miso_m, rxv_m, busy_m, ferr_m;
  logic       miso_l, rxv_l, busy_l, ferr_l;
  logic [9:0] rxd_m, rxd_l;

  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  spi_slave_param #(.DW(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(15)) dut_msb (
    .CLK(CLK), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_m),
    .rx_valid(rxv_m), .rx_data(rxd_m), .tx_valid(tx_valid), .tx_data(tx_data),
    .busy(busy_m), .frame_err(ferr_m)
  );

  spi_slave_param #(.DW(8), .LSB_FIRST(1'b1), .TX_TIMEOUT(15)) dut_lsb (
    .CLK(CLK), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_l),
    .rx_valid(rxv_l), .rx_data(rxd_l), .tx_valid(tx_valid), .tx_data(tx_data),
    .busy(busy_l), .frame_err(ferr_l)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_miso_m"}, 32'(miso_m), 32'd0);
    chk({tag, "_miso_l"}, 32'(miso_l), 32'd0);
    chk({tag, "_rxv"},    32'(rxv_m),  32'd0);
    chk({tag, "_rxd_m"},  32'(rxd_m),  32'd0);
    chk({tag, "_rxd_l"},  32'(rxd_l),  32'd0);
    chk({tag, "_busy"},   32'(busy_m), 32'd0);
    chk({tag, "_ferr"},   32'(ferr_m), 32'd0);
  endtask

  // SS_n falls, one IDLE cycle, then ten bits; leaves SS_n low after one extra cycle.
  task automatic frame(input string tag, input logic [9:0] f,
                       input logic [9:0] exp_m, input logic [9:0] exp_l);
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick;
    chk({tag, "_busy"}, 32'(busy_m), 32'd1);
    for (int i = 9; i >= 0; i--) begin
      MOSI = f[i];
      tick;
      chk({tag, "_rxv"},  32'(rxv_m),  32'(i == 0));
      chk({tag, "_miso"}, 32'(miso_m | miso_l), 32'd0);
    end
    chk({tag, "_rxd_m"}, 32'(rxd_m), 32'(exp_m));
    chk({tag, "_rxd_l"}, 32'(rxd_l), 32'(exp_l));
    chk({tag, "_rxv_l"}, 32'(rxv_l), 32'd1);
    MOSI = 1'b0;
    tick;
    chk({tag, "_rxv_drop"}, 32'(rxv_m), 32'd0);
  endtask

  // seq_* hold the expected MISO bits with the first one at bit 7.
  task automatic shift_check(input string tag, input logic [7:0] seq_m, input logic [7:0] seq_l);
    for (int i = 7; i >= 0; i--) begin
      tick;
      chk({tag, "_miso_m"}, 32'(miso_m), 32'(seq_m[i]));
      chk({tag, "_miso_l"}, 32'(miso_l), 32'(seq_l[i]));
    end
    tick;
    chk({tag, "_miso_end"}, 32'(miso_m | miso_l), 32'd0);
  endtask

  // A tx_valid pulse while not in READ_WAIT must not reach MISO.
  task automatic tx_ignored(input string tag);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick;
    tx_valid = 1'b0;
    tick;
    chk({tag, "_miso1"}, 32'(miso_m | miso_l), 32'd0);
    tick;
    chk({tag, "_miso2"}, 32'(miso_m | miso_l), 32'd0);
  endtask

  task automatic deselect(input string tag);
    SS_n = 1'b1;
    tick;
    chk({tag, "_ferr"}, 32'(ferr_m | ferr_l), 32'd0);
    chk({tag, "_busy"}, 32'(busy_m | busy_l), 32'd0);
  endtask

  initial begin
    // reset
    tick;
    tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;
    chk("reset_busy", 32'(busy_m), 32'd0);

    // write frame
    frame("wr", 10'h0AB, 10'h0AB, 10'h0D5);
    deselect("wr_end");

    // read-address frame
    frame("radd", 10'h2C5, 10'h2C5, 10'h2A3);
    deselect("radd_end");

    // read-data frame, tx_valid three cycles into READ_WAIT
    frame("rdat", 10'h300, 10'h300, 10'h300);
    tick;
    chk("rdat_wait2", 32'(miso_m | miso_l), 32'd0);
    tick;
    chk("rdat_wait3", 32'(miso_m | miso_l), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick;
    tx_valid = 1'b0;
    chk("rdat_capture", 32'(miso_m | miso_l), 32'd0);
    shift_check("tx_a5", 8'b1010_0101, 8'b1010_0101);
    deselect("rdat_end");

    // addr_pending cleared: a 1-command is READ_ADD again
    frame("radd2", 10'h2C5, 10'h2C5, 10'h2A3);
    tx_ignored("radd2_txv");
    deselect("radd2_end");

    // read-data with tx_data=01 shows the bit order difference
    frame("rdat2", 10'h300, 10'h300, 10'h300);
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    tick;
    tx_valid = 1'b0;
    shift_check("tx_01", 8'b0000_0001, 8'b1000_0000);
    deselect("rdat2_end");

    // abort after four bits of a write
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      MOSI = (i == 2);
      tick;
      chk("abort_rxv", 32'(rxv_m), 32'd0);
    end
    SS_n = 1'b1;
    tick;
    chk("abort_ferr_m", 32'(ferr_m), 32'd1);
    chk("abort_ferr_l", 32'(ferr_l), 32'd1);
    chk("abort_busy",   32'(busy_m), 32'd0);
    chk("abort_rxv_n",  32'(rxv_m),  32'd0);
    chk("abort_rxd",    32'(rxd_m),  32'h300);
    tick;
    chk("abort_ferr_pulse", 32'(ferr_m), 32'd0);

    // tx timeout: 15 READ_WAIT cycles without tx_valid
    frame("to_radd", 10'h2C5, 10'h2C5, 10'h2A3);
    deselect("to_radd_end");
    frame("to_rdat", 10'h300, 10'h300, 10'h300);
    for (int k = 2; k <= 15; k++) begin
      tick;
      chk("to_ferr", 32'(ferr_m), 32'(k == 15));
      chk("to_miso", 32'(miso_m | miso_l), 32'd0);
    end
    tick;
    chk("to_ferr_pulse", 32'(ferr_m), 32'd0);
    tx_ignored("to_late_txv");
    deselect("to_end");

    // addr_pending survived the timeout; reset in the middle of READ_TX
    frame("rst_rdat", 10'h300, 10'h300, 10'h300);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick;
    tx_valid = 1'b0;
    tick;
    chk("rst_tx_first", 32'(miso_m), 32'd1);
    tick;
    rst_n = 1'b0;
    tick;
    chk_all_zero("rst_mid_tx");
    rst_n = 1'b1;
    deselect("rst_idle");

    // reset cleared addr_pending: a 1-command is READ_ADD
    frame("rst_radd", 10'h2C5, 10'h2C5, 10'h2A3);
    tx_ignored("rst_radd_txv");
    deselect("rst_radd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
